// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load writebacks into one register-bank
// write port through a small FIFO, with bypass lookup on pending entries.
//
// Ports:
//   clock, reset_n                     - clock, synchronous active-low reset
//   alu_valid/address/data             - ALU writeback request
//   memory_valid/address/data          - load writeback request
//   ready                              - both requests can be accepted
//   write/write_address/write_data     - register bank write port
//   lookup_address_k                   - register bank read addresses
//   lookup_hit_k/lookup_data_k         - bypass result per read port
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [5:0]  alu_address,
    input  logic [63:0] alu_data,
    input  logic        memory_valid,
    input  logic [5:0]  memory_address,
    input  logic [63:0] memory_data,
    output logic        ready,
    output logic        write,
    output logic [5:0]  write_address,
    output logic [63:0] write_data,
    input  logic [5:0]  lookup_address_1,
    input  logic [5:0]  lookup_address_2,
    output logic        lookup_hit_1,
    output logic        lookup_hit_2,
    output logic [63:0] lookup_data_1,
    output logic [63:0] lookup_data_2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [5:0]    addr_mem [DEPTH];
    logic [63:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          mem_acc;
    logic          alu_acc;
    logic          deq;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] enq_n;

    // Two free slots are required so both requests can always be taken.
    assign ready    = reset_n && (count <= CW'(DEPTH - 2));
    assign mem_acc  = memory_valid && ready;
    assign alu_acc  = alu_valid && ready;
    assign deq      = (count != '0);
    assign enq_n    = CW'(mem_acc) + CW'(alu_acc);
    // Memory request is older, so the ALU entry lands behind it.
    assign alu_slot = tail + AW'(mem_acc);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq);
            tail  <= tail + AW'(enq_n);
            count <= count + enq_n - CW'(deq);
        end
    end

    always_ff @(posedge clock) begin
        if (mem_acc) begin
            addr_mem[tail] <= memory_address;
            data_mem[tail] <= memory_data;
        end
        if (alu_acc) begin
            addr_mem[alu_slot] <= alu_address;
            data_mem[alu_slot] <= alu_data;
        end
    end

    assign write         = deq;
    assign write_address = deq ? addr_mem[head] : '0;
    assign write_data    = deq ? data_mem[head] : '0;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx           = '0;
        lookup_hit_1  = 1'b0;
        lookup_hit_2  = 1'b0;
        lookup_data_1 = '0;
        lookup_data_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count) begin
                if (addr_mem[idx] == lookup_address_1) begin
                    lookup_hit_1  = 1'b1;
                    lookup_data_1 = data_mem[idx];
                end
                if (addr_mem[idx] == lookup_address_2) begin
                    lookup_hit_2  = 1'b1;
                    lookup_data_2 = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH = 4).
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_writeback_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [5:0]  alu_address;
    logic [63:0] alu_data;
    logic        memory_valid;
    logic [5:0]  memory_address;
    logic [63:0] memory_data;
    logic        ready;
    logic        write;
    logic [5:0]  write_address;
    logic [63:0] write_data;
    logic [5:0]  lookup_address_1;
    logic [5:0]  lookup_address_2;
    logic        lookup_hit_1;
    logic        lookup_hit_2;
    logic [63:0] lookup_data_1;
    logic [63:0] lookup_data_2;

    int tests = 0;
    int fails = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .alu_valid(alu_valid),
        .alu_address(alu_address),
        .alu_data(alu_data),
        .memory_valid(memory_valid),
        .memory_address(memory_address),
        .memory_data(memory_data),
        .ready(ready),
        .write(write),
        .write_address(write_address),
        .write_data(write_data),
        .lookup_address_1(lookup_address_1),
        .lookup_address_2(lookup_address_2),
        .lookup_hit_1(lookup_hit_1),
        .lookup_hit_2(lookup_hit_2),
        .lookup_data_1(lookup_data_1),
        .lookup_data_2(lookup_data_2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid    = 1'b0;
        memory_valid = 1'b0;
    endtask

    logic [63:0] bp_data [7];
    logic [5:0]  bp_addr [7];
    logic        bp_wr   [7];
    logic        bp_rdy  [7];

    initial begin
        int k;
        logic acc;

        bp_data = '{64'h100, 64'h200, 64'h101, 64'h201, 64'h102, 64'h202, 64'h0};
        bp_addr = '{6'd10, 6'd20, 6'd11, 6'd21, 6'd12, 6'd22, 6'd0};
        bp_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bp_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        reset_n          = 1'b0;
        alu_valid        = 1'b0;
        alu_address      = '0;
        alu_data         = '0;
        memory_valid     = 1'b0;
        memory_address   = '0;
        memory_data      = '0;
        lookup_address_1 = '0;
        lookup_address_2 = '0;

        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_waddr", 64'(write_address), 64'd0);
        chk("rst_wdata", write_data, 64'd0);
        chk("rst_hit1", 64'(lookup_hit_1), 64'd0);
        chk("rst_data2", lookup_data_2, 64'd0);

        reset_n = 1'b1;
        #1;
        chk("rel_ready", 64'(ready), 64'd1);

        // single ALU write
        alu_valid   = 1'b1;
        alu_address = 6'd5;
        alu_data    = 64'hAA;
        tick();
        idle();
        lookup_address_1 = 6'd5;
        #1;
        chk("single_write", 64'(write), 64'd1);
        chk("single_addr", 64'(write_address), 64'd5);
        chk("single_data", write_data, 64'hAA);
        chk("single_hit", 64'(lookup_hit_1), 64'd1);
        chk("single_ldata", lookup_data_1, 64'hAA);
        tick();
        chk("single_done", 64'(write), 64'd0);

        // same-cycle ordering, memory first
        memory_valid   = 1'b1;
        memory_address = 6'd3;
        memory_data    = 64'h11;
        alu_valid      = 1'b1;
        alu_address    = 6'd3;
        alu_data       = 64'h22;
        lookup_address_1 = 6'd3;
        lookup_address_2 = 6'd7;
        #1;
        chk("inflight_nohit", 64'(lookup_hit_1), 64'd0);
        tick();
        idle();
        chk("ord1_addr", 64'(write_address), 64'd3);
        chk("ord1_data", write_data, 64'h11);
        chk("ord1_hit", 64'(lookup_hit_1), 64'd1);
        chk("ord1_young", lookup_data_1, 64'h22);
        chk("miss_hit2", 64'(lookup_hit_2), 64'd0);
        chk("miss_data2", lookup_data_2, 64'd0);
        tick();
        chk("ord2_write", 64'(write), 64'd1);
        chk("ord2_data", write_data, 64'h22);
        chk("ord2_ldata", lookup_data_1, 64'h22);
        tick();
        chk("ord_done", 64'(write), 64'd0);
        chk("ord_nohit", 64'(lookup_hit_1), 64'd0);

        // backpressure with held dual requests
        k = 0;
        for (int c = 0; c < 7; c++) begin
            memory_valid   = (k < 3);
            memory_address = 6'(10 + k);
            memory_data    = 64'h100 + 64'(k);
            alu_valid      = (k < 3);
            alu_address    = 6'(20 + k);
            alu_data       = 64'h200 + 64'(k);
            #1;
            acc = ready && (k < 3);
            tick();
            if (acc) k++;
            chk($sformatf("bp_write%0d", c), 64'(write), 64'(bp_wr[c]));
            chk($sformatf("bp_addr%0d", c), 64'(write_address), 64'(bp_addr[c]));
            chk($sformatf("bp_data%0d", c), write_data, bp_data[c]);
            chk($sformatf("bp_ready%0d", c), 64'(ready), 64'(bp_rdy[c]));
        end
        idle();
        chk("bp_all_taken", 64'(k), 64'd3);

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            alu_valid   = 1'b1;
            alu_address = 6'(30 + i);
            alu_data    = 64'(i);
            tick();
            chk($sformatf("wrap_data%0d", i), write_data, 64'(i));
            chk($sformatf("wrap_addr%0d", i), 64'(write_address), 64'(30 + i));
        end
        idle();
        tick();
        chk("wrap_empty", 64'(write), 64'd0);
        chk("wrap_ready", 64'(ready), 64'd1);

        // reset with three pending entries
        memory_valid   = 1'b1;
        memory_address = 6'd40;
        memory_data    = 64'hA0;
        alu_valid      = 1'b1;
        alu_address    = 6'd41;
        alu_data       = 64'hA1;
        tick();
        memory_address = 6'd42;
        memory_data    = 64'hA2;
        alu_address    = 6'd43;
        alu_data       = 64'hA3;
        tick();
        idle();
        lookup_address_1 = 6'd42;
        lookup_address_2 = 6'd41;
        #1;
        chk("pend_ready", 64'(ready), 64'd0);
        chk("pend_hit", lookup_data_1, 64'hA2);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_ready1", 64'(ready), 64'd1);
        chk("midrst_hit1", 64'(lookup_hit_1), 64'd0);
        chk("midrst_hit2", 64'(lookup_hit_2), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midrst_quiet%0d", i), 64'(write), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
